// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - measures period/high/low of a divided clock sampled as data
// Reports lock, period/duty mismatch against exp_div, and stuck-clock timeout.
module clk_div_monitor #(
  parameter int CNT_W    = 8,
  parameter int SYNC_EN  = 1,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clk_in,
  input  logic [CNT_W:0]   exp_div,
  input  logic             err_clr,
  output logic [CNT_W:0]   period,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic             meas_vld,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [MC_W-1:0]  LOCK_MC = MC_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic s;
  logic s_d_q;
  logic rise;
  logic fall;

  generate
    if (SYNC_EN != 0) begin : g_sync
      logic sync1_q;
      logic sync2_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
        end else begin
          sync1_q <= clk_in;
          sync2_q <= sync1_q;
        end
      end
      assign s = sync2_q;
    end else begin : g_nosync
      assign s = clk_in;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_d_q <= 1'b0;
    end else begin
      s_d_q <= s;
    end
  end

  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
  logic [CNT_W:0]   period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic             vld_q, vld_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;
  logic [MC_W-1:0]  mc_q, mc_d;
  logic             has_prev_q, has_prev_d;

  logic             publish;
  logic             sat;
  logic             mismatch;
  logic             duty_bad;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] diff;

  always_comb begin
    state_d    = state_q;
    hi_cnt_d   = hi_cnt_q;
    lo_cnt_d   = lo_cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    low_d      = low_q;
    vld_d      = 1'b0;
    locked_d   = locked_q;
    timeout_d  = timeout_q;
    mc_d       = mc_q;
    has_prev_d = has_prev_q;
    publish    = 1'b0;
    sat        = 1'b0;
    mismatch   = 1'b0;
    duty_bad   = 1'b0;
    sum        = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
    diff       = (hi_cnt_q >= lo_cnt_q) ? (hi_cnt_q - lo_cnt_q) : (lo_cnt_q - hi_cnt_q);

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d  = ST_HIGH;
          hi_cnt_d = CNT_W'(1);
          lo_cnt_d = '0;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d  = ST_LOW;
          lo_cnt_d = CNT_W'(1);
        end else if (s) begin
          if (hi_cnt_q == CNT_MAX) sat = 1'b1;
          else                     hi_cnt_d = hi_cnt_q + CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (rise) begin
          publish  = 1'b1;
          state_d  = ST_HIGH;
          hi_cnt_d = CNT_W'(1);
        end else if (!s) begin
          if (lo_cnt_q == CNT_MAX) sat = 1'b1;
          else                     lo_cnt_d = lo_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (publish) begin
      period_d   = sum;
      high_d     = hi_cnt_q;
      low_d      = lo_cnt_q;
      vld_d      = 1'b1;
      timeout_d  = 1'b0;
      has_prev_d = 1'b1;
      // period_q still holds the previous publish; has_prev_q guards the first one after IDLE
      if (has_prev_q && (sum == period_q)) begin
        mc_d = (mc_q == LOCK_MC) ? mc_q : mc_q + MC_W'(1);
      end else begin
        mc_d = MC_W'(1);
      end
      locked_d = (mc_d == LOCK_MC);
      if (exp_div != '0) begin
        duty_bad = exp_div[0] ? (diff != CNT_W'(1)) : (diff != '0);
        mismatch = (sum != exp_div) || duty_bad;
      end
    end

    if (sat) begin
      timeout_d  = 1'b1;
      locked_d   = 1'b0;
      mc_d       = '0;
      has_prev_d = 1'b0;
      state_d    = ST_IDLE;
      hi_cnt_d   = '0;
      lo_cnt_d   = '0;
    end

    err_d = (err_q & ~err_clr) | mismatch;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      hi_cnt_q   <= '0;
      lo_cnt_q   <= '0;
      period_q   <= '0;
      high_q     <= '0;
      low_q      <= '0;
      vld_q      <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      mc_q       <= '0;
      has_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_cnt_q   <= hi_cnt_d;
      lo_cnt_q   <= lo_cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      low_q      <= low_d;
      vld_q      <= vld_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      mc_q       <= mc_d;
      has_prev_q <= has_prev_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign low_time  = low_q;
  assign meas_vld  = vld_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - bench for clk_div_monitor, raw and synchronized sampling
module tb_clk_div_monitor;

  localparam int CNT_W = 4;
  localparam int LOCKN = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rstn;
  logic             clk_in;
  logic [CNT_W:0]   exp_div;
  logic             err_clr;
  logic [CNT_W:0]   per0, per1;
  logic [CNT_W-1:0] hi0, hi1, lo0, lo1;
  logic             vld0, vld1, lk0, lk1, er0, er1, to0, to1;

  clk_div_monitor #(.CNT_W(CNT_W), .SYNC_EN(0), .LOCK_CNT(LOCKN)) u_dut0 (
    .clk(clk), .rstn(rstn), .clk_in(clk_in), .exp_div(exp_div), .err_clr(err_clr),
    .period(per0), .high_time(hi0), .low_time(lo0), .meas_vld(vld0),
    .locked(lk0), .err(er0), .timeout(to0)
  );

  clk_div_monitor #(.CNT_W(CNT_W), .SYNC_EN(1), .LOCK_CNT(LOCKN)) u_dut1 (
    .clk(clk), .rstn(rstn), .clk_in(clk_in), .exp_div(exp_div), .err_clr(err_clr),
    .period(per1), .high_time(hi1), .low_time(lo1), .meas_vld(vld1),
    .locked(lk1), .err(er1), .timeout(to1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rand_clr = 0;
  bit sh1 = 0, sh2 = 0;

  // Run-length reference model: index 0 sees clk_in directly, index 1 sees it two samples late.
  int m_prev[2], m_run[2], m_hirun[2], m_npub[2], m_eq[2], m_last[2];
  bit m_armed[2], m_havehi[2];
  int e_per[2], e_hi[2], e_lo[2];
  bit e_vld[2], e_lk[2], e_err[2], e_to[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_prev[m] = 0; m_run[m] = 0; m_hirun[m] = 0; m_npub[m] = 0; m_eq[m] = 0; m_last[m] = 0;
      m_armed[m] = 0; m_havehi[m] = 0;
      e_per[m] = 0; e_hi[m] = 0; e_lo[m] = 0;
      e_vld[m] = 0; e_lk[m] = 0; e_err[m] = 0; e_to[m] = 0;
    end
    sh1 = 0; sh2 = 0;
  endtask

  task automatic model_step(input int m, input int s, input int ed, input bit clr);
    bit mism;
    int p, d;
    mism = 0;
    e_vld[m] = 0;
    if (s != m_prev[m]) begin
      if (s != 0) begin
        if (m_armed[m] && m_havehi[m]) begin
          p = m_hirun[m] + m_run[m];
          e_per[m] = p; e_hi[m] = m_hirun[m]; e_lo[m] = m_run[m];
          e_vld[m] = 1; e_to[m] = 0;
          if (m_npub[m] > 0 && p == m_last[m]) m_eq[m]++;
          else m_eq[m] = 1;
          m_last[m] = p;
          m_npub[m]++;
          e_lk[m] = (m_eq[m] >= LOCKN);
          if (ed != 0) begin
            d = m_hirun[m] - m_run[m];
            if (ed % 2 == 1) mism = (d != 1 && d != -1);
            else             mism = (d != 0);
            if (p != ed) mism = 1;
          end
        end
        m_armed[m] = 1; m_havehi[m] = 0;
      end else if (m_armed[m]) begin
        m_hirun[m] = m_run[m]; m_havehi[m] = 1;
      end
      m_run[m] = 1;
    end else begin
      m_run[m]++;
      if (m_armed[m] && m_run[m] > MAXC) begin
        e_to[m] = 1; e_lk[m] = 0;
        m_armed[m] = 0; m_havehi[m] = 0; m_npub[m] = 0; m_eq[m] = 0;
      end
    end
    m_prev[m] = s;
    e_err[m] = (e_err[m] && !clr) || mism;
  endtask

  task automatic check_out(input int m, input int per, input int hi, input int lo,
                           input bit vld, input bit lk, input bit er, input bit to);
    vectors++;
    if (per != e_per[m] || hi != e_hi[m] || lo != e_lo[m] || vld != e_vld[m] ||
        lk != e_lk[m] || er != e_err[m] || to != e_to[m]) begin
      miscompares++;
      $display("FAIL model cyc%0d dut%0d got per=%0d hi=%0d lo=%0d vld=%0d lk=%0d err=%0d to=%0d want per=%0d hi=%0d lo=%0d vld=%0d lk=%0d err=%0d to=%0d",
               cyc, m, per, hi, lo, vld, lk, er, to,
               e_per[m], e_hi[m], e_lo[m], e_vld[m], e_lk[m], e_err[m], e_to[m]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cyc%0d got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input bit ci);
    bit s1;
    if (rand_clr) err_clr = ($urandom_range(0, 7) == 0);
    clk_in = ci;
    s1 = sh2; sh2 = sh1; sh1 = ci;
    model_step(0, int'(ci), int'(exp_div), err_clr);
    model_step(1, int'(s1), int'(exp_div), err_clr);
    @(posedge clk); #1;
    cyc++;
    check_out(0, per0, hi0, lo0, vld0, lk0, er0, to0);
    check_out(1, per1, hi1, lo1, vld1, lk1, er1, to1);
  endtask

  task automatic drive_period(input int hi, input int lo);
    repeat (hi) tick(1'b1);
    repeat (lo) tick(1'b0);
  endtask

  task automatic do_reset();
    rstn = 1'b0; clk_in = 1'b0; err_clr = 1'b0;
    #1;
    model_reset();
    check_out(0, per0, hi0, lo0, vld0, lk0, er0, to0);
    check_out(1, per1, hi1, lo1, vld1, lk1, er1, to1);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  typedef struct {
    int hi; int lo; int ed; int n;
    int x_per; int x_hi; int x_lo; int x_err; int x_lk;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{2, 2, 4, 4, 4, 2, 2, 0, 1};
    tbl[1] = '{2, 2, 4, 3, 4, 2, 2, 0, 0};
    tbl[2] = '{3, 3, 6, 5, 6, 3, 3, 0, 1};
    tbl[3] = '{3, 2, 5, 4, 5, 3, 2, 0, 1};
    tbl[4] = '{4, 1, 5, 2, 5, 4, 1, 1, 0};
    tbl[5] = '{4, 4, 6, 4, 8, 4, 4, 1, 1};
    tbl[6] = '{1, 1, 2, 4, 2, 1, 1, 0, 1};
    tbl[7] = '{15, 15, 0, 4, 30, 15, 15, 0, 1};
    tbl[8] = '{2, 3, 0, 1, 5, 2, 3, 0, 0};
    tbl[9] = '{5, 3, 8, 4, 8, 5, 3, 1, 1};

    rstn = 1'b0; clk_in = 1'b0; exp_div = '0; err_clr = 1'b0;
    model_reset();
    do_reset();

    for (int i = 0; i < 10; i++) begin
      do_reset();
      exp_div = tbl[i].ed[CNT_W:0];
      repeat (tbl[i].n) drive_period(tbl[i].hi, tbl[i].lo);
      tick(1'b1);
      check_val("tbl_vld",    vld0, 1);
      check_val("tbl_period", per0, tbl[i].x_per);
      check_val("tbl_high",   hi0,  tbl[i].x_hi);
      check_val("tbl_low",    lo0,  tbl[i].x_lo);
      check_val("tbl_err",    er0,  tbl[i].x_err);
      check_val("tbl_locked", lk0,  tbl[i].x_lk);
    end

    // clk/6 locks, switch to clk/8 drops lock and flags err, then re-locks
    do_reset();
    exp_div = 5'd6;
    repeat (6) drive_period(3, 3);
    tick(1'b1);
    check_val("div6_locked", lk0, 1);
    check_val("div6_err", er0, 0);
    repeat (3) tick(1'b1);
    repeat (4) tick(1'b0);
    tick(1'b1);
    check_val("div8_period", per0, 8);
    check_val("div8_unlock", lk0, 0);
    check_val("div8_err", er0, 1);
    repeat (3) tick(1'b1);
    repeat (4) tick(1'b0);
    repeat (3) drive_period(4, 4);
    tick(1'b1);
    check_val("div8_relock", lk0, 1);

    // odd divider duty check and err_clr priority
    do_reset();
    exp_div = 5'd5;
    repeat (3) drive_period(3, 2);
    tick(1'b1);
    check_val("odd_ok_err", er0, 0);
    repeat (3) tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    check_val("odd_duty_per", per0, 5);
    check_val("odd_duty_err", er0, 1);
    err_clr = 1'b1; tick(1'b1); err_clr = 1'b0;
    check_val("errclr", er0, 0);
    repeat (2) tick(1'b1);
    tick(1'b0);
    err_clr = 1'b1; tick(1'b1); err_clr = 1'b0;
    check_val("errclr_vs_new", er0, 1);

    // stuck-high timeout then recovery
    do_reset();
    exp_div = 5'd4;
    repeat (6) drive_period(2, 2);
    tick(1'b1);
    check_val("pre_to_locked", lk0, 1);
    repeat (14) tick(1'b1);
    check_val("hi15_no_to", to0, 0);
    tick(1'b1);
    check_val("timeout_set", to0, 1);
    check_val("timeout_unlock", lk0, 0);
    repeat (2) tick(1'b0);
    drive_period(2, 2);
    check_val("timeout_held", to0, 1);
    tick(1'b1);
    check_val("timeout_clr", to0, 0);
    check_val("timeout_clr_per", per0, 4);

    // synchronized instance publishes two samples later than the raw one
    do_reset();
    exp_div = 5'd4;
    drive_period(2, 2);
    tick(1'b1);
    check_val("sync_lat_raw", vld0, 1);
    check_val("sync_lat_a", vld1, 0);
    tick(1'b1);
    check_val("sync_lat_b", vld1, 0);
    tick(1'b0);
    check_val("sync_lat_c", vld1, 1);
    check_val("sync_per", per1, 4);
    tick(1'b0);
    repeat (2) drive_period(2, 2);
    tick(1'b1); tick(1'b1); tick(1'b0);
    do_reset();
    repeat (4) drive_period(2, 2);

    // randomized periods, divider expectations, clears and resets
    rand_clr = 1;
    for (int k = 0; k < 80; k++) begin
      int h, l, r;
      h = $urandom_range(1, 6);
      l = $urandom_range(1, 6);
      if ($urandom_range(0, 9) == 0) h = $urandom_range(13, 18);
      if ($urandom_range(0, 9) == 0) l = $urandom_range(13, 18);
      r = $urandom_range(0, 3);
      if (r == 0) exp_div = '0;
      else if (r == 1) exp_div = (h + l <= 31) ? 5'(h + l) : 5'd0;
      else if (r == 2) exp_div = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 24) == 0) do_reset();
      drive_period(h, l);
    end
    rand_clr = 0;
    err_clr = 1'b0;
    tick(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
